// File: rtl/mem_preload_if.sv
// Command, word-stream and memory-write bundle for the burst preload controller.
// master = command/stream source; slave = the preload controller.
interface mem_preload_if #(
   parameter int unsigned DPW       = 32,
   parameter int unsigned ADW       = 32,
   parameter int unsigned NUM_TGT   = 2,
   parameter int unsigned MAX_WORDS = 1024
);
   localparam int unsigned TW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
   localparam int unsigned LW = $clog2(MAX_WORDS) + 1;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [TW-1:0]      cmd_tgt;
   logic [ADW-1:0]     cmd_base;
   logic [LW-1:0]      cmd_len;
   logic               s_valid;
   logic               s_ready;
   logic [DPW-1:0]     s_data;
   logic [NUM_TGT-1:0] mem_we;
   logic [ADW-1:0]     mem_addr;
   logic [DPW-1:0]     mem_wdata;

   modport master (
      output cmd_valid, cmd_tgt, cmd_base, cmd_len, s_valid, s_data,
      input  cmd_ready, s_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  cmd_valid, cmd_tgt, cmd_base, cmd_len, s_valid, s_data,
      output cmd_ready, s_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_preload_ctrl.sv
// Burst preload controller: writes a command-described word stream into imem/dmem
// and holds the core until released. `PRELOAD_CHECKSUM_EN adds a per-burst word sum.
module mem_preload_ctrl #(
   parameter int unsigned DPW       = 32,
   parameter int unsigned ADW       = 32,
   parameter int unsigned NUM_TGT   = 2,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic           clk,
   input  logic           arst_n,
   mem_preload_if.slave   bus,
   input  logic           go,
   output logic           core_hold,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [DPW-1:0] checksum
);
   localparam int unsigned TW  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
   localparam int unsigned LW  = $clog2(MAX_WORDS) + 1;
   localparam int unsigned INC = DPW / 8;

   typedef enum logic {S_IDLE, S_LOAD} state_t;

   state_t             state, state_nx;
   logic [TW-1:0]      tgt_q, tgt_nx;
   logic [ADW-1:0]     addr_q, addr_nx;
   logic [LW-1:0]      rem_q, rem_nx;
   logic               cmd_ready_nx, s_ready_nx, hold_nx, busy_nx, done_nx, err_nx;
   logic [NUM_TGT-1:0] we_nx;
   logic [ADW-1:0]     maddr_nx;
   logic [DPW-1:0]     wdata_nx;
   logic               len_bad, tgt_bad, cmd_bad;

   // A target index is only checkable when TW bits can encode values >= NUM_TGT.
   if ((1 << TW) == NUM_TGT) begin : g_tgt_full
      assign tgt_bad = 1'b0;
   end else begin : g_tgt_chk
      assign tgt_bad = (32'(bus.cmd_tgt) >= NUM_TGT);
   end

   assign len_bad = (bus.cmd_len == '0) || (bus.cmd_len > LW'(MAX_WORDS));
   assign cmd_bad = len_bad || tgt_bad;

   always_comb begin
      state_nx     = state;
      tgt_nx       = tgt_q;
      addr_nx      = addr_q;
      rem_nx       = rem_q;
      cmd_ready_nx = 1'b1;
      s_ready_nx   = 1'b0;
      busy_nx      = 1'b0;
      done_nx      = 1'b0;
      err_nx       = 1'b0;
      hold_nx      = core_hold;
      we_nx        = '0;
      maddr_nx     = bus.mem_addr;
      wdata_nx     = bus.mem_wdata;
      case (state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               // Command beats a simultaneous go: the core stays held.
               hold_nx = 1'b1;
               tgt_nx  = bus.cmd_tgt;
               addr_nx = bus.cmd_base;
               rem_nx  = bus.cmd_len;
               if (cmd_bad) begin
                  err_nx = 1'b1;
               end else begin
                  state_nx     = S_LOAD;
                  cmd_ready_nx = 1'b0;
                  s_ready_nx   = 1'b1;
                  busy_nx      = 1'b1;
               end
            end else if (go) begin
               hold_nx = 1'b0;
            end
         end
         S_LOAD: begin
            cmd_ready_nx = 1'b0;
            s_ready_nx   = 1'b1;
            busy_nx      = 1'b1;
            if (bus.s_valid) begin
               we_nx    = NUM_TGT'(1) << tgt_q;
               maddr_nx = addr_q;
               wdata_nx = bus.s_data;
               addr_nx  = addr_q + ADW'(INC);
               rem_nx   = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_nx     = S_IDLE;
                  cmd_ready_nx = 1'b1;
                  s_ready_nx   = 1'b0;
                  busy_nx      = 1'b0;
                  done_nx      = 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state         <= S_IDLE;
         tgt_q         <= '0;
         addr_q        <= '0;
         rem_q         <= '0;
         bus.cmd_ready <= 1'b1;
         bus.s_ready   <= 1'b0;
         bus.mem_we    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         core_hold     <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_nx;
         tgt_q         <= tgt_nx;
         addr_q        <= addr_nx;
         rem_q         <= rem_nx;
         bus.cmd_ready <= cmd_ready_nx;
         bus.s_ready   <= s_ready_nx;
         bus.mem_we    <= we_nx;
         bus.mem_addr  <= maddr_nx;
         bus.mem_wdata <= wdata_nx;
         core_hold     <= hold_nx;
         busy          <= busy_nx;
         done          <= done_nx;
         err           <= err_nx;
      end
   end

`ifdef PRELOAD_CHECKSUM_EN
   logic           sum_clr, sum_acc;
   logic [DPW-1:0] sum_q;

   assign sum_clr = (state == S_IDLE) && bus.cmd_valid && !cmd_bad;
   assign sum_acc = (state == S_LOAD) && bus.s_valid;

   // Sum lands on the same edge as the matching mem_we.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)      sum_q <= '0;
      else if (sum_clr) sum_q <= '0;
      else if (sum_acc) sum_q <= sum_q + bus.s_data;
   end
   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif
endmodule

// File: tb/tb_mem_preload_ctrl.sv
// Scoreboard bench for mem_preload_ctrl: expected writes are queued as words are
// driven and checked when mem_we appears. A second NUM_TGT=3 instance covers bad targets.
module tb_mem_preload_ctrl;
   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   mem_preload_if #(.DPW(32), .ADW(32), .NUM_TGT(2), .MAX_WORDS(1024)) bus ();
   logic        go, core_hold, busy, done, err;
   logic [31:0] checksum;

   mem_preload_ctrl #(.DPW(32), .ADW(32), .NUM_TGT(2), .MAX_WORDS(1024)) u_dut (
      .clk(clk), .arst_n(arst_n), .bus(bus), .go(go), .core_hold(core_hold),
      .busy(busy), .done(done), .err(err), .checksum(checksum)
   );

   mem_preload_if #(.DPW(32), .ADW(32), .NUM_TGT(3), .MAX_WORDS(1024)) bus3 ();
   logic        go3, core_hold3, busy3, done3, err3;
   logic [31:0] checksum3;

   mem_preload_ctrl #(.DPW(32), .ADW(32), .NUM_TGT(3), .MAX_WORDS(1024)) u_dut3 (
      .clk(clk), .arst_n(arst_n), .bus(bus3), .go(go3), .core_hold(core_hold3),
      .busy(busy3), .done(done3), .err(err3), .checksum(checksum3)
   );

   typedef struct packed {
      logic [1:0]  we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
      logic [31:0] sum;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          n_done = 0;
   int          exp_done = 0;
   int          cur_tgt;
   logic [31:0] cur_addr;
   int          cur_rem;
   logic [31:0] run_sum;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rst_vals(input string tag);
      chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
      chk({tag, "_core_hold"}, 64'(core_hold), 64'd1);
      chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
      chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_checksum"}, 64'(checksum), 64'd0);
   endtask

   task automatic send_cmd(input int tgt, input logic [31:0] base, input int len,
                           input bit exp_err);
      bus.cmd_valid = 1'b1;
      bus.cmd_tgt   = 1'(tgt);
      bus.cmd_base  = base;
      bus.cmd_len   = 11'(len);
      tick();
      bus.cmd_valid = 1'b0;
      chk("cmd_err", 64'(err), 64'(exp_err));
      if (exp_err) begin
         chk("rej_cmd_ready", 64'(bus.cmd_ready), 64'd1);
         chk("rej_busy", 64'(busy), 64'd0);
         tick();
         chk("err_one_cycle", 64'(err), 64'd0);
      end else begin
         chk("acc_s_ready", 64'(bus.s_ready), 64'd1);
         chk("acc_busy", 64'(busy), 64'd1);
         cur_tgt  = tgt;
         cur_addr = base;
         cur_rem  = len;
         run_sum  = '0;
      end
   endtask

   task automatic send_word(input logic [31:0] d);
      exp_t e;
      chk("word_s_ready", 64'(bus.s_ready), 64'd1);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      run_sum     = run_sum + d;
      e.we   = 2'(1 << cur_tgt);
      e.addr = cur_addr;
      e.data = d;
      e.last = (cur_rem == 1);
      e.sum  = run_sum;
      exp_q.push_back(e);
      if (e.last) exp_done++;
      cur_addr = cur_addr + 32'd4;
      cur_rem--;
      tick();
      bus.s_valid = 1'b0;
   endtask

   // Write monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (done) n_done++;
      if (bus.mem_we != '0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_we", 64'(bus.mem_we), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mem_we", 64'(bus.mem_we), 64'(e.we));
            chk("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(e.data));
            chk("done_with_we", 64'(done), 64'(e.last));
            chk("busy_with_we", 64'(busy), 64'(!e.last));
            chk("cmd_ready_with_we", 64'(bus.cmd_ready), 64'(e.last));
`ifdef PRELOAD_CHECKSUM_EN
            chk("checksum", 64'(checksum), 64'(e.sum));
`else
            chk("checksum_tied", 64'(checksum), 64'd0);
`endif
         end
      end else if (done) begin
         chk("done_without_we", 64'(done), 64'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_tgt = '0; bus.cmd_base = '0; bus.cmd_len = '0;
      bus.s_valid = 1'b0; bus.s_data = '0; go = 1'b0;
      bus3.cmd_valid = 1'b0; bus3.cmd_tgt = '0; bus3.cmd_base = '0; bus3.cmd_len = '0;
      bus3.s_valid = 1'b0; bus3.s_data = '0; go3 = 1'b0;

      #12;
      check_rst_vals("por");
      @(negedge clk);
      arst_n = 1'b1;
      tick();

      // Basic dmem burst.
      send_cmd(1, 32'h0, 2, 1'b0);
      send_word(32'h5);
      send_word(32'h8);

      // imem burst with a stall between words 2 and 3.
      send_cmd(0, 32'h100, 4, 1'b0);
      send_word(32'h1111_0000);
      send_word(32'h2222_0000);
      for (int i = 0; i < 3; i++) begin
         chk("gap_busy", 64'(busy), 64'd1);
         tick();
      end
      send_word(32'h3333_0000);
      send_word(32'h4444_0000);
      tick();

      // Rejected commands: zero length, over-long.
      send_cmd(0, 32'h40, 0, 1'b1);
      send_cmd(1, 32'h40, 1025, 1'b1);
      send_cmd(0, 32'h40, 1024, 1'b0);
      for (int i = 0; i < 1024; i++) send_word(32'(i * 3 + 1));
      tick();

      // Address wrap-around.
      send_cmd(1, 32'hFFFF_FFFC, 2, 1'b0);
      chk("wrap_no_err", 64'(err), 64'd0);
      send_word(32'hAAAA_5555);
      send_word(32'h5555_AAAA);

      // go ignored in LOAD, honoured in IDLE; cmd beats go.
      send_cmd(0, 32'h200, 2, 1'b0);
      go = 1'b1;
      send_word(32'h77);
      go = 1'b0;
      chk("hold_in_load", 64'(core_hold), 64'd1);
      send_word(32'h99);
      chk("hold_after_done", 64'(core_hold), 64'd1);
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("hold_released", 64'(core_hold), 64'd0);
      go = 1'b1;
      send_cmd(1, 32'h300, 1, 1'b0);
      go = 1'b0;
      chk("cmd_beats_go", 64'(core_hold), 64'd1);
      send_word(32'hCAFE);
      tick();

      // Reset mid-burst after two of four words.
      send_cmd(0, 32'h400, 4, 1'b0);
      send_word(32'hD1);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hD2;
      send_word(32'hD2);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hD3;
      @(negedge clk);
      #1;
      arst_n = 1'b0;
      #1;
      check_rst_vals("mid_rst");
      tick();
      tick();
      @(negedge clk);
      arst_n = 1'b1;
      tick();
      tick();
      bus.s_valid = 1'b0;
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_hold", 64'(core_hold), 64'd1);
      send_cmd(1, 32'h500, 1, 1'b0);
      send_word(32'hE0);
      tick();

      // NUM_TGT=3 instance: tgt 3 rejected, tgt 2 accepted.
      bus3.cmd_valid = 1'b1; bus3.cmd_tgt = 2'd3; bus3.cmd_base = 32'h80; bus3.cmd_len = 11'd1;
      tick();
      bus3.cmd_valid = 1'b0;
      chk("t3_bad_tgt_err", 64'(err3), 64'd1);
      chk("t3_bad_tgt_busy", 64'(busy3), 64'd0);
      tick();
      chk("t3_err_one_cycle", 64'(err3), 64'd0);
      chk("t3_no_we", 64'(bus3.mem_we), 64'd0);
      bus3.cmd_valid = 1'b1; bus3.cmd_tgt = 2'd2; bus3.cmd_base = 32'h80; bus3.cmd_len = 11'd1;
      tick();
      bus3.cmd_valid = 1'b0;
      chk("t3_ok_err", 64'(err3), 64'd0);
      bus3.s_valid = 1'b1; bus3.s_data = 32'hAB;
      tick();
      bus3.s_valid = 1'b0;
      chk("t3_we", 64'(bus3.mem_we), 64'b100);
      chk("t3_addr", 64'(bus3.mem_addr), 64'h80);
      chk("t3_data", 64'(bus3.mem_wdata), 64'hAB);
      chk("t3_done", 64'(done3), 64'd1);
      tick();

      tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("done_count", 64'(n_done), 64'(exp_done));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
